sprite_rom_arbiter: RTL

Sequencer and round-robin arbiter that shares the single read port of the game-over sprite ROM between two pixel requesters, for example the game-over overlay renderer and the banner/score renderer. Each requester asks for a burst of consecutive 8-pixel bytes from one sprite row. The block grants one burst at a time and drives the ROM address/read-enable once per cycle. It returns the ROM bytes tagged with owner and last-beat flags. It sits between the VGA-side renderers and the ROM.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/rr_arbiter_2.sv | 16 +
 rtl/sprite_rom_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared widths, FSM state encoding and latched-request layout for the sprite ROM arbiter.
package sprite_pkg;
  localparam int SPRITE_ID_W = 3;
  localparam int COORD_W     = 5;
  localparam int PIX_W       = 8;
  localparam int ROM_LAT     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // While a burst runs, x holds the current column and len the remaining count.
  typedef struct packed {
    logic [SPRITE_ID_W-1:0] id;
    logic [COORD_W-1:0]     y;
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     len;
  } req_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares the sprite ROM read port between two burst requesters; one byte address per cycle,
// responses tagged with owner and last-beat flags.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ROM_LAT = sprite_pkg::ROM_LAT
) (
  input  logic                                        CLOCK_50,
  input  logic                                        RESET_N,
  // Transfer when REQ_VALID[i] && REQ_READY[i]; fields stay stable while VALID is high.
  input  logic [N_REQ-1:0]                            REQ_VALID,
  output logic [N_REQ-1:0]                            REQ_READY,
  input  logic [N_REQ-1:0][sprite_pkg::SPRITE_ID_W-1:0] REQ_ID,
  input  logic [N_REQ-1:0][sprite_pkg::COORD_W-1:0]   REQ_Y,
  input  logic [N_REQ-1:0][sprite_pkg::COORD_W-1:0]   REQ_X,
  input  logic [N_REQ-1:0][sprite_pkg::COORD_W-1:0]   REQ_LEN,
  output logic                                        ROM_RE,
  output logic [sprite_pkg::SPRITE_ID_W-1:0]          ROM_ID,
  output logic [sprite_pkg::COORD_W-1:0]              ROM_X,
  output logic [sprite_pkg::COORD_W-1:0]              ROM_Y,
  input  logic [sprite_pkg::PIX_W-1:0]                ROM_PIXEL,
  output logic                                        RSP_VALID,
  output logic                                        RSP_OWNER,
  output logic [sprite_pkg::PIX_W-1:0]                RSP_DATA,
  output logic                                        RSP_LAST,
  output logic                                        BUSY
);
  import sprite_pkg::*;

  state_t             state, state_nxt;
  req_t               req_q;
  logic               ptr;
  logic [1:0]         grant;
  logic               winner;
  logic               accept;
  logic [ROM_LAT-1:0] vld_pipe, own_pipe, last_pipe;

  rr_arbiter_2 u_arb (
    .valid    (REQ_VALID),
    .last_ptr (ptr),
    .grant    (grant)
  );

  assign winner    = grant[1];
  // Gated by RESET_N so READY reads 0 while reset is held even with requests pending.
  assign accept    = (state == IDLE) && RESET_N && (|REQ_VALID);
  assign REQ_READY = accept ? grant : '0;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (req_q.len == '0) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The column only advances while more bytes remain, so the address holds after the burst.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr   <= 1'b1;
      req_q <= '0;
    end else if (accept) begin
      ptr       <= winner;
      req_q.id  <= REQ_ID[winner];
      req_q.y   <= REQ_Y[winner];
      req_q.x   <= REQ_X[winner];
      req_q.len <= REQ_LEN[winner];
    end else if (state == ISSUE && req_q.len != '0) begin
      req_q.x   <= req_q.x + 1'b1;
      req_q.len <= req_q.len - 1'b1;
    end
  end

  assign ROM_RE = (state == ISSUE);
  assign ROM_ID = req_q.id;
  assign ROM_Y  = req_q.y;
  assign ROM_X  = req_q.x;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_pipe  <= '0;
      own_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= ROM_RE;
      own_pipe[0]  <= ptr;
      last_pipe[0] <= ROM_RE && (req_q.len == '0);
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        own_pipe[i]  <= own_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign RSP_VALID = vld_pipe[ROM_LAT-1];
  assign RSP_OWNER = own_pipe[ROM_LAT-1];
  assign RSP_LAST  = last_pipe[ROM_LAT-1];
  assign RSP_DATA  = RSP_VALID ? ROM_PIXEL : '0;
  assign BUSY      = (state != IDLE);
endmodule
